// File: rtl/ram32x4_pkg.sv
// Shared widths, types and display constants for the 32x4 RAM exerciser.
package ram32x4_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 32;
  // One synchronizer lane each for pressed, write_enable, address and data_in
  localparam int SYNC_W = ADDR_W + DATA_W + 2;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [6:0]        seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/ram32x4_seg7.sv
// Combinational 4-bit hex to active-low seven-segment decoder (bit 0 = a ... bit 6 = g).
module seg7
  import ram32x4_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  // Hex digit lookup; unknown codes blank the digit
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_hex)
      4'h0:    o_seg = 7'b1000000;
      4'h1:    o_seg = 7'b1111001;
      4'h2:    o_seg = 7'b0100100;
      4'h3:    o_seg = 7'b0110000;
      4'h4:    o_seg = 7'b0011001;
      4'h5:    o_seg = 7'b0010010;
      4'h6:    o_seg = 7'b0000010;
      4'h7:    o_seg = 7'b1111000;
      4'h8:    o_seg = 7'b0000000;
      4'h9:    o_seg = 7'b0010000;
      4'hA:    o_seg = 7'b0001000;
      4'hB:    o_seg = 7'b0000011;
      4'hC:    o_seg = 7'b1000110;
      4'hD:    o_seg = 7'b0100001;
      4'hE:    o_seg = 7'b0000110;
      4'hF:    o_seg = 7'b0001110;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ram32x4_board_top.sv
// DE1-SoC RAM exerciser: synchronized switches/button step a 32x4 RAM, shown on seven-segment displays.
// Optional macro RAM32X4_MEM_CLEAR_EN makes the memory flop-based and cleared by reset.
module ram32x4_board_top
  import ram32x4_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step_key_n,
  input  logic       write_enable,
  input  logic [4:0] address,
  input  logic [3:0] data_in,
  output logic [6:0] hex5,
  output logic [6:0] hex4,
  output logic [6:0] hex3,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0
);

  logic [SYNC_W-1:0]                   w_sync_in;
  logic [SYNC_STAGES-1:0][SYNC_W-1:0]  r_sync;
  logic [SYNC_W-1:0]                   w_sync_out;
  logic                                w_pressed;
  logic                                w_we_sync;
  addr_t                               w_addr_sync;
  data_t                               w_din_sync;
  logic                                r_pressed_prev;
  logic                                w_step;
  addr_t                               r_addr_q;
  data_t                               r_din_q;
  logic                                r_we_q;
  data_t                               r_data_out_q;
  data_t                               r_mem [DEPTH];

  assign w_sync_in = {~step_key_n, write_enable, address, data_in};

  // Input synchronizer chains, all lanes shifted together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_sync_in};
    end
  end

  assign w_sync_out  = r_sync[SYNC_STAGES-1];
  assign w_pressed   = w_sync_out[SYNC_W-1];
  assign w_we_sync   = w_sync_out[SYNC_W-2];
  assign w_addr_sync = w_sync_out[DATA_W +: ADDR_W];
  assign w_din_sync  = w_sync_out[DATA_W-1:0];

  // Rising-edge detector on the synchronized button
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pressed_prev <= 1'b0;
    end else begin
      r_pressed_prev <= w_pressed;
    end
  end

  assign w_step = w_pressed & ~r_pressed_prev;

  // Input capture register and read-data register; mem read uses pre-step address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr_q     <= '0;
      r_din_q      <= '0;
      r_we_q       <= 1'b0;
      r_data_out_q <= '0;
    end else if (w_step) begin
      r_addr_q     <= w_addr_sync;
      r_din_q      <= w_din_sync;
      r_we_q       <= w_we_sync;
      r_data_out_q <= r_mem[r_addr_q];
    end else begin
      r_addr_q     <= r_addr_q;
      r_din_q      <= r_din_q;
      r_we_q       <= r_we_q;
      r_data_out_q <= r_data_out_q;
    end
  end

`ifdef RAM32X4_MEM_CLEAR_EN
  // Flop-based memory, cleared by reset; write commits the previously captured request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_step && r_we_q) begin
      r_mem[r_addr_q] <= r_din_q;
    end else begin
      r_mem <= r_mem;
    end
  end
`else
  // Memory without reset; a step while reset is asserted is impossible since w_step is held low
  always_ff @(posedge clk) begin
    if (w_step && r_we_q) begin
      r_mem[r_addr_q] <= r_din_q;
    end
  end
`endif

  seg7 u_seg_hex5 (.i_hex({3'b000, w_addr_sync[4]}), .o_seg(hex5));
  seg7 u_seg_hex4 (.i_hex(w_addr_sync[3:0]),         .o_seg(hex4));
  seg7 u_seg_hex2 (.i_hex(w_din_sync),               .o_seg(hex2));
  seg7 u_seg_hex0 (.i_hex(r_data_out_q),             .o_seg(hex0));

  assign hex3 = SEG_BLANK;
  assign hex1 = SEG_BLANK;

endmodule

// File: tb/tb_ram32x4_board_top.sv
// Self-checking bench for ram32x4_board_top: table-driven step vectors with a hex0 scoreboard plus corner sequences.
module tb_ram32x4_board_top;

  localparam int SYNC = 2;
`ifdef RAM32X4_MEM_CLEAR_EN
  localparam bit MEM_CLR = 1'b1;
`else
  localparam bit MEM_CLR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       step_key_n = 1'b1;
  logic       write_enable = 1'b0;
  logic [4:0] address = 5'h00;
  logic [3:0] data_in = 4'h0;
  logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       we;
    logic [4:0] a;
    logic [3:0] d;
    bit         chk;
    logic [3:0] exp;
  } vec_t;

  vec_t       vecs [17];
  logic [6:0] sb_q [$];

  ram32x4_board_top #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .step_key_n(step_key_n), .write_enable(write_enable),
    .address(address), .data_in(data_in),
    .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sw(input logic we, input logic [4:0] a, input logic [3:0] d);
    write_enable = we;
    address      = a;
    data_in      = d;
    repeat (SYNC + 1) tick();
  endtask

  task automatic do_step();
    step_key_n = 1'b0;
    repeat (SYNC + 2) tick();
    step_key_n = 1'b1;
    repeat (SYNC + 2) tick();
  endtask

  // Push the expected readout when the step is driven, pop and compare once it lands
  task automatic step_sb(input string name, input logic [3:0] exp);
    logic [6:0] e;
    sb_q.push_back(seg_of(exp));
    do_step();
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      check(name, hex0, e);
    end
  endtask

  initial begin
    logic [6:0]  prev;
    int          changes;
    logic [4:0]  rd_a [5];
    logic [3:0]  rd_e [5];

    vecs[0]  = '{1'b1, 5'h0A, 4'hA, 1'b0, 4'h0};
    vecs[1]  = '{1'b1, 5'h02, 4'h5, 1'b0, 4'h0};
    vecs[2]  = '{1'b0, 5'h0A, 4'h0, 1'b0, 4'h0};
    vecs[3]  = '{1'b0, 5'h0A, 4'h0, 1'b1, 4'hA};
    vecs[4]  = '{1'b0, 5'h02, 4'h1, 1'b1, 4'hA};
    vecs[5]  = '{1'b0, 5'h02, 4'h2, 1'b1, 4'h5};
    vecs[6]  = '{1'b1, 5'h1F, 4'hF, 1'b1, 4'h5};
    vecs[7]  = '{1'b1, 5'h00, 4'h3, 1'b0, 4'h0};
    vecs[8]  = '{1'b0, 5'h1F, 4'h7, 1'b0, 4'h0};
    vecs[9]  = '{1'b0, 5'h00, 4'h8, 1'b1, 4'hF};
    vecs[10] = '{1'b0, 5'h05, 4'hB, 1'b1, 4'h3};
    vecs[11] = '{1'b1, 5'h05, 4'h9, 1'b0, 4'h0};
    vecs[12] = '{1'b0, 5'h05, 4'hD, 1'b0, 4'h0};
    vecs[13] = '{1'b0, 5'h05, 4'hE, 1'b1, 4'h9};
    vecs[14] = '{1'b1, 5'h05, 4'h2, 1'b1, 4'h9};
    vecs[15] = '{1'b0, 5'h05, 4'h4, 1'b1, 4'h9};
    vecs[16] = '{1'b0, 5'h05, 4'h6, 1'b1, 4'h2};

    // Reset state, plus a button press and release entirely inside reset
    repeat (3) tick();
    check("rst_hex0", hex0, 7'b1000000);
    check("rst_hex2", hex2, 7'b1000000);
    check("rst_hex4", hex4, 7'b1000000);
    check("rst_hex5", hex5, 7'b1000000);
    check("rst_hex3", hex3, 7'b1111111);
    check("rst_hex1", hex1, 7'b1111111);
    step_key_n = 1'b0;
    repeat (SYNC + 2) tick();
    step_key_n = 1'b1;
    repeat (SYNC + 2) tick();
    reset = 1'b1;
    repeat (SYNC + 4) tick();
    check("post_rst_hex0", hex0, 7'b1000000);
    check("post_rst_hex4", hex4, 7'b1000000);

    // Table-driven write/read sequence
    for (int i = 0; i < 17; i++) begin
      set_sw(vecs[i].we, vecs[i].a, vecs[i].d);
      check($sformatf("v%0d_hex5", i), hex5, seg_of({3'b000, vecs[i].a[4]}));
      check($sformatf("v%0d_hex4", i), hex4, seg_of(vecs[i].a[3:0]));
      check($sformatf("v%0d_hex2", i), hex2, seg_of(vecs[i].d));
      if (vecs[i].chk) begin
        step_sb($sformatf("v%0d_hex0", i), vecs[i].exp);
      end else begin
        do_step();
      end
    end

    // Long press: one step only (reads mem[05]=2; a second step would show A)
    set_sw(1'b0, 5'h0A, 4'h0);
    prev       = hex0;
    changes    = 0;
    step_key_n = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (hex0 !== prev) changes++;
      prev = hex0;
    end
    step_key_n = 1'b1;
    repeat (SYNC + 2) tick();
    checks++;
    if (changes > 1) begin
      errors++;
      $display("FAIL hold_changes: got %0d expected at most 1", changes);
    end
    check("hold_hex0", hex0, seg_of(4'h2));

    // Step latency: hex0 changes exactly on edge SYNC+1 after the press
    step_key_n = 1'b0;
    repeat (SYNC) tick();
    check("lat_before", hex0, seg_of(4'h2));
    tick();
    check("lat_at", hex0, seg_of(4'hA));
    step_key_n = 1'b1;
    repeat (SYNC + 2) tick();

    // Capture a write to 05, then reset before it commits
    set_sw(1'b1, 5'h05, 4'hC);
    step_sb("cap_hex0", 4'hA);
    reset = 1'b0;
    repeat (2) tick();
    check("mid_rst_hex0", hex0, 7'b1000000);
    check("mid_rst_hex2", hex2, 7'b1000000);
    check("mid_rst_hex4", hex4, 7'b1000000);
    write_enable = 1'b0;
    reset        = 1'b1;
    rd_a = '{5'h05, 5'h0A, 5'h1F, 5'h02, 5'h02};
    rd_e = '{4'h3, 4'h2, 4'hA, 4'hF, 4'h5};
    for (int i = 0; i < 5; i++) begin
      set_sw(1'b0, rd_a[i], 4'h0);
      step_sb($sformatf("after_rst_rd%0d", i), MEM_CLR ? 4'h0 : rd_e[i]);
    end

    // Max address/data appear on the displays exactly SYNC edges later
    set_sw(1'b0, 5'h00, 4'h0);
    address = 5'h1F;
    data_in = 4'hF;
    repeat (SYNC - 1) tick();
    check("sync_early_hex4", hex4, 7'b1000000);
    tick();
    check("sync_hex5", hex5, 7'b1111001);
    check("sync_hex4", hex4, 7'b0001110);
    check("sync_hex2", hex2, 7'b0001110);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
